// File: rtl/power_meter.sv
// Shot-power meter: charge/latch FSM plus a one-stage VGA overlay that draws the power bar.
// Optional build macro POWER_GRADIENT_EN colours the fill by power level.
module power_meter #(
  parameter int unsigned POWER_W     = 5,
  parameter int unsigned STEP_PX     = 4,
  parameter int unsigned BORDER      = 4,
  parameter int unsigned BAR_H       = 20,
  parameter int unsigned YPOS        = 40,
  parameter int unsigned XPOS_P1     = 200,
  parameter int unsigned XPOS_P2     = 824,
  parameter int unsigned TICK_FRAMES = 2,
  parameter int unsigned HOLD_FRAMES = 60,
  parameter logic [11:0] FILL_RGB    = 12'hEA2,
  parameter logic [11:0] BORDER_RGB  = 12'h000
) (
  input  logic               clk60MHz,
  input  logic               rst,
  input  logic               charge_i,
  input  logic [1:0]         current_player_i,
  output logic [POWER_W-1:0] power_o,
  output logic               power_valid_o,
  output logic               busy_o,
  input  logic [10:0]        vga_in_hcount_i,
  input  logic [10:0]        vga_in_vcount_i,
  input  logic               vga_in_hsync_i,
  input  logic               vga_in_vsync_i,
  input  logic               vga_in_hblnk_i,
  input  logic               vga_in_vblnk_i,
  input  logic [11:0]        vga_in_rgb_i,
  output logic [10:0]        vga_out_hcount_o,
  output logic [10:0]        vga_out_vcount_o,
  output logic               vga_out_hsync_o,
  output logic               vga_out_vsync_o,
  output logic               vga_out_hblnk_o,
  output logic               vga_out_vblnk_o,
  output logic [11:0]        vga_out_rgb_o
);

  localparam int unsigned CW = POWER_W + 12;
  localparam int unsigned FrameMax = (HOLD_FRAMES > TICK_FRAMES) ? HOLD_FRAMES : TICK_FRAMES;
  localparam int unsigned FcW = $clog2(FrameMax + 1);
  localparam logic [POWER_W-1:0] MaxPower = '1;

  typedef enum logic [1:0] {StIdle, StCharge, StShow} state_e;

  state_e             state_q;
  logic [POWER_W-1:0] power_q;
  logic               dir_q;  // 0: counting up, 1: counting down
  logic [FcW-1:0]     frame_cnt_q;
  logic [1:0]         player_q;
  logic               vblnk_q;
  logic               power_valid_q;

  logic               tick;
  logic               player_ok;
  logic [POWER_W-1:0] power_step;
  logic               dir_step;

  assign tick      = vga_in_vblnk_i & ~vblnk_q;
  assign player_ok = (current_player_i == 2'b01) || (current_player_i == 2'b10);

  // Ping-pong step: bounce off MAX and 0 instead of wrapping.
  always_comb begin
    power_step = power_q;
    dir_step   = dir_q;
    if (!dir_q) begin
      if (power_q == MaxPower) begin
        dir_step   = 1'b1;
        power_step = power_q - 1'b1;
      end else begin
        power_step = power_q + 1'b1;
      end
    end else begin
      if (power_q == '0) begin
        dir_step   = 1'b0;
        power_step = power_q + 1'b1;
      end else begin
        power_step = power_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      state_q       <= StIdle;
      power_q       <= '0;
      dir_q         <= 1'b0;
      frame_cnt_q   <= '0;
      player_q      <= 2'b00;
      vblnk_q       <= 1'b0;
      power_valid_q <= 1'b0;
    end else begin
      vblnk_q       <= vga_in_vblnk_i;
      power_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (charge_i && player_ok) begin
            state_q     <= StCharge;
            player_q    <= current_player_i;
            power_q     <= '0;
            dir_q       <= 1'b0;
            frame_cnt_q <= '0;
          end
        end
        StCharge: begin
          if (current_player_i != player_q) begin
            state_q     <= StIdle;
            power_q     <= '0;
            frame_cnt_q <= '0;
          end else if (!charge_i) begin
            // Release beats a coincident tick: the value is latched unstepped.
            state_q       <= StShow;
            power_valid_q <= 1'b1;
            frame_cnt_q   <= '0;
          end else if (tick) begin
            if (frame_cnt_q == FcW'(TICK_FRAMES - 1)) begin
              frame_cnt_q <= '0;
              power_q     <= power_step;
              dir_q       <= dir_step;
            end else begin
              frame_cnt_q <= frame_cnt_q + 1'b1;
            end
          end
        end
        StShow: begin
          if (current_player_i != player_q) begin
            state_q     <= StIdle;
            power_q     <= '0;
            frame_cnt_q <= '0;
          end else if (tick) begin
            if (frame_cnt_q == FcW'(HOLD_FRAMES - 1)) begin
              state_q     <= StIdle;
              power_q     <= '0;
              frame_cnt_q <= '0;
            end else begin
              frame_cnt_q <= frame_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign power_o       = power_q;
  assign power_valid_o = power_valid_q;
  assign busy_o        = (state_q == StCharge) || (state_q == StShow);

  // Bar geometry; additions on the pixel side avoid negative intermediates.
  logic [CW-1:0] h, v, len, wid;
  logic          in_y, outer_y;
  logic          fill_x1, inner_x1, outer_x1;
  logic          fill_x2, inner_x2, outer_x2;
  logic          fill_hit, border_hit;
  logic [11:0]   fill_rgb;
  logic [11:0]   rgb_d;

  always_comb begin
    h   = CW'(vga_in_hcount_i);
    v   = CW'(vga_in_vcount_i);
    len = CW'(power_q) * CW'(STEP_PX);
    wid = CW'(MaxPower) * CW'(STEP_PX);

    in_y    = (v >= CW'(YPOS)) && (v <= CW'(YPOS + BAR_H));
    outer_y = (v + CW'(BORDER) >= CW'(YPOS)) && (v <= CW'(YPOS + BAR_H + BORDER));

    fill_x1  = (h + len >= CW'(XPOS_P1)) && (h <= CW'(XPOS_P1));
    inner_x1 = (h + wid >= CW'(XPOS_P1)) && (h <= CW'(XPOS_P1));
    outer_x1 = (h + wid + CW'(BORDER) >= CW'(XPOS_P1)) && (h <= CW'(XPOS_P1 + BORDER));

    fill_x2  = (h >= CW'(XPOS_P2)) && (h <= CW'(XPOS_P2) + len);
    inner_x2 = (h >= CW'(XPOS_P2)) && (h <= CW'(XPOS_P2) + wid);
    outer_x2 = (h + CW'(BORDER) >= CW'(XPOS_P2)) && (h <= CW'(XPOS_P2 + BORDER) + wid);

    fill_hit   = 1'b0;
    border_hit = 1'b0;
    if (current_player_i == 2'b01) begin
      fill_hit   = fill_x1 && in_y;
      border_hit = outer_x1 && outer_y && !(inner_x1 && in_y);
    end else if (current_player_i == 2'b10) begin
      fill_hit   = fill_x2 && in_y;
      border_hit = outer_x2 && outer_y && !(inner_x2 && in_y);
    end
  end

`ifdef POWER_GRADIENT_EN
  localparam logic [POWER_W-1:0] LowLevel = POWER_W'(((1 << POWER_W) - 1) / 3);
  localparam logic [POWER_W-1:0] MidLevel = POWER_W'((2 * ((1 << POWER_W) - 1)) / 3);

  always_comb begin
    if (power_q <= LowLevel) begin
      fill_rgb = 12'h0C0;
    end else if (power_q <= MidLevel) begin
      fill_rgb = 12'hEA2;
    end else begin
      fill_rgb = 12'hE20;
    end
  end
`else
  assign fill_rgb = FILL_RGB;
`endif

  always_comb begin
    rgb_d = vga_in_rgb_i;
    if (busy_o && !vga_in_hblnk_i && !vga_in_vblnk_i) begin
      if (fill_hit) begin
        rgb_d = fill_rgb;
      end else if (border_hit) begin
        rgb_d = BORDER_RGB;
      end
    end
  end

  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      vga_out_hcount_o <= '0;
      vga_out_vcount_o <= '0;
      vga_out_hsync_o  <= 1'b0;
      vga_out_vsync_o  <= 1'b0;
      vga_out_hblnk_o  <= 1'b0;
      vga_out_vblnk_o  <= 1'b0;
      vga_out_rgb_o    <= '0;
    end else begin
      vga_out_hcount_o <= vga_in_hcount_i;
      vga_out_vcount_o <= vga_in_vcount_i;
      vga_out_hsync_o  <= vga_in_hsync_i;
      vga_out_vsync_o  <= vga_in_vsync_i;
      vga_out_hblnk_o  <= vga_in_hblnk_i;
      vga_out_vblnk_o  <= vga_in_vblnk_i;
      vga_out_rgb_o    <= rgb_d;
    end
  end

endmodule

// File: tb/tb_power_meter.sv
// Directed bench for power_meter: charge/latch sequences plus a table of overlay pixels.
module tb_power_meter;

  logic        clk = 1'b0;
  logic        rst;
  logic        charge;
  logic [1:0]  player;
  logic [4:0]  power;
  logic        power_valid;
  logic        busy;
  logic [10:0] hcount, vcount;
  logic        hsync, vsync, hblnk, vblnk;
  logic [11:0] rgb;
  logic [10:0] out_hcount, out_vcount;
  logic        out_hsync, out_vsync, out_hblnk, out_vblnk;
  logic [11:0] out_rgb;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  power_meter dut (
    .clk60MHz        (clk),
    .rst             (rst),
    .charge_i        (charge),
    .current_player_i(player),
    .power_o         (power),
    .power_valid_o   (power_valid),
    .busy_o          (busy),
    .vga_in_hcount_i (hcount),
    .vga_in_vcount_i (vcount),
    .vga_in_hsync_i  (hsync),
    .vga_in_vsync_i  (vsync),
    .vga_in_hblnk_i  (hblnk),
    .vga_in_vblnk_i  (vblnk),
    .vga_in_rgb_i    (rgb),
    .vga_out_hcount_o(out_hcount),
    .vga_out_vcount_o(out_vcount),
    .vga_out_hsync_o (out_hsync),
    .vga_out_vsync_o (out_vsync),
    .vga_out_hblnk_o (out_hblnk),
    .vga_out_vblnk_o (out_vblnk),
    .vga_out_rgb_o   (out_rgb)
  );

  typedef struct {
    int          h;
    int          v;
    logic [11:0] rgb_in;
    logic        blank;
    logic [11:0] exp;
  } pix_t;

  pix_t pix[19];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One frame: vblnk rising edge produces exactly one tick.
  task automatic frame();
    vblnk = 1'b1;
    cyc();
    cyc();
    vblnk = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  function automatic logic [11:0] fill_for(input int p);
`ifdef POWER_GRADIENT_EN
    if (p <= 10) return 12'h0C0;
    else if (p <= 20) return 12'hEA2;
    else return 12'hE20;
`else
    return 12'hEA2;
`endif
  endfunction

  // Drive a pixel, then move the inputs away before sampling so a zero-latency path shows up.
  task automatic apply_pix(input string name, input pix_t p);
    hcount = 11'(p.h);
    vcount = 11'(p.v);
    rgb    = p.rgb_in;
    hblnk  = p.blank;
    cyc();
    hcount = '0;
    vcount = '0;
    rgb    = '0;
    hblnk  = 1'b0;
    #1;
    check({name, " rgb"}, int'(out_rgb), int'(p.exp));
    check({name, " hcount"}, int'(out_hcount), p.h);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int   maxp;
    int   zeros;
    pix_t gp;

    pix[0]  = '{170, 50, 12'h123, 1'b0, fill_for(10)};
    pix[1]  = '{161, 50, 12'h234, 1'b0, fill_for(10)};
    pix[2]  = '{159, 50, 12'h345, 1'b0, 12'h345};
    pix[3]  = '{198, 38, 12'h456, 1'b0, 12'h000};
    pix[4]  = '{202, 50, 12'h567, 1'b0, 12'h000};
    pix[5]  = '{200, 60, 12'h678, 1'b0, fill_for(10)};
    pix[6]  = '{200, 61, 12'h789, 1'b0, 12'h000};
    pix[7]  = '{72,  50, 12'h89A, 1'b0, 12'h000};
    pix[8]  = '{71,  50, 12'h9AB, 1'b0, 12'h9AB};
    pix[9]  = '{76,  50, 12'hABC, 1'b0, 12'hABC};
    pix[10] = '{205, 50, 12'hBCD, 1'b0, 12'hBCD};
    pix[11] = '{170, 50, 12'hCDE, 1'b1, 12'hCDE};
    pix[12] = '{170, 35, 12'hDEF, 1'b0, 12'hDEF};
    pix[13] = '{822, 50, 12'h111, 1'b0, 12'h111};
    pix[14] = '{834, 50, 12'h222, 1'b0, fill_for(10)};
    pix[15] = '{865, 50, 12'h333, 1'b0, 12'h333};
    pix[16] = '{822, 50, 12'h444, 1'b0, 12'h000};
    pix[17] = '{864, 50, 12'h555, 1'b0, fill_for(10)};
    pix[18] = '{170, 50, 12'h666, 1'b0, 12'h666};

    rst = 1'b1; charge = 1'b0; player = 2'b00;
    hcount = 11'd5; vcount = 11'd7; hsync = 1'b0; vsync = 1'b0;
    hblnk = 1'b0; vblnk = 1'b0; rgb = 12'hFFF;
    cyc();
    cyc();
    check("reset power", int'(power), 0);
    check("reset busy", int'(busy), 0);
    check("reset valid", int'(power_valid), 0);
    check("reset rgb", int'(out_rgb), 0);
    check("reset hcount", int'(out_hcount), 0);
    rst = 1'b0; hcount = '0; vcount = '0; rgb = '0;
    cyc();

    // Reset in the middle of a charge
    player = 2'b01; charge = 1'b1;
    cyc();
    check("charge enter busy", int'(busy), 1);
    frames(18);
    check("power after 18 frames", int'(power), 9);
    rst = 1'b1; rgb = 12'hFFF;
    cyc();
    check("midreset power", int'(power), 0);
    check("midreset busy", int'(busy), 0);
    check("midreset rgb", int'(out_rgb), 0);
    rst = 1'b0; charge = 1'b0; rgb = '0;
    cyc();
    check("after reset idle", int'(busy), 0);

    // 8 frames charge, release, hold 60 frames
    charge = 1'b1;
    cyc();
    check("start power", int'(power), 0);
    frames(8);
    check("power 8 frames", int'(power), 4);
    charge = 1'b0;
    cyc();
    check("release valid", int'(power_valid), 1);
    check("release power", int'(power), 4);
    check("release busy", int'(busy), 1);
    charge = 1'b1;
    cyc();
    check("valid one cycle", int'(power_valid), 0);
    frames(30);
    check("show ignores charge", int'(power), 4);
    charge = 1'b0;
    frames(29);
    check("hold 59 busy", int'(busy), 1);
    check("hold 59 power", int'(power), 4);
    frame();
    check("hold end busy", int'(busy), 0);
    check("hold end power", int'(power), 0);

    // Ping-pong over 70 frames
    charge = 1'b1;
    cyc();
    maxp = 0; zeros = 0;
    for (int f = 1; f <= 70; f++) begin
      frame();
      if (int'(power) > maxp) maxp = int'(power);
      if (f >= 2 && power == 5'd0) zeros++;
      if (f == 62) check("power at frame 62", int'(power), 31);
    end
    check("peak power", maxp, 31);
    check("no wrap to zero", zeros, 0);
    check("power at frame 70", int'(power), 27);

    // Abort on player change
    player = 2'b10;
    cyc();
    check("abort busy", int'(busy), 0);
    check("abort power", int'(power), 0);
    check("abort valid", int'(power_valid), 0);
    charge = 1'b0;
    cyc();
    player = 2'b11; charge = 1'b1;
    cyc(); cyc(); cyc();
    check("player 11 idle", int'(busy), 0);
    charge = 1'b0; player = 2'b01;
    cyc();

    // Release coincident with a stepping tick
    charge = 1'b1;
    cyc();
    frames(3);
    check("power 3 frames", int'(power), 1);
    charge = 1'b0; vblnk = 1'b1;
    cyc();
    check("release+tick power", int'(power), 1);
    check("release+tick valid", int'(power_valid), 1);
    vblnk = 1'b0;
    player = 2'b00;
    cyc();
    check("show abort busy", int'(busy), 0);
    check("show abort power", int'(power), 0);
    check("show abort valid", int'(power_valid), 0);

    // Player 1 overlay at power 10
    player = 2'b01; charge = 1'b1;
    cyc();
    frames(20);
    check("p1 power", int'(power), 10);
    for (int i = 0; i <= 13; i++) apply_pix($sformatf("p1 pix%0d", i), pix[i]);

    // Player 2 overlay and fill colour per level
    player = 2'b10;
    cyc();
    check("switch abort busy", int'(busy), 0);
    cyc();
    check("p2 enter busy", int'(busy), 1);
    frames(10);
    gp = '{826, 50, 12'h777, 1'b0, fill_for(5)};
    apply_pix("fill power5", gp);
    frames(10);
    check("p2 power", int'(power), 10);
    for (int i = 14; i <= 18; i++) apply_pix($sformatf("p2 pix%0d", i), pix[i]);
    frames(10);
    gp = '{826, 50, 12'h777, 1'b0, fill_for(15)};
    apply_pix("fill power15", gp);
    frames(20);
    check("p2 power 25", int'(power), 25);
    gp = '{826, 50, 12'h777, 1'b0, fill_for(25)};
    apply_pix("fill power25", gp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
